// File: rtl/sseg_mmio_display.sv
// MMIO seven-segment display: double-dabble BCD conversion of stores to ADDR, 4-digit refresh.
// Optional define LEADING_ZERO_BLANK_EN turns off the anodes of leading zero digits.
module sseg_mmio_display #(
    parameter logic [31:0] ADDR        = 32'h11000040,
    parameter int unsigned REFRESH_CNT = 100000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic        BUSY,
    output logic [7:0]  CATHODES,
    output logic [3:0]  ANODES
);

    localparam int unsigned CntW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic            pend_q, pend_d;
    logic [15:0]     pend_val_q, pend_val_d;
    logic [15:0]     src_q, src_d;
    logic [15:0]     bin_q, bin_d;
    logic [19:0]     bcd_q, bcd_d;
    logic [3:0]      iter_q, iter_d;
    logic [15:0]     disp_q, disp_d;
    logic            ovf_q, ovf_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      dig_q, dig_d;

    logic        wr_acc;
    logic [19:0] bcd_adj;
    logic [19:0] bcd_shf;
    logic [15:0] bin_shf;
    logic [3:0]  cur_digit;
    logic [7:0]  seg;

    assign wr_acc = IOBUS_WR && (IOBUS_ADDR == ADDR);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        bcd_shf = {bcd_adj[18:0], bin_q[15]};
        bin_shf = {bin_q[14:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        src_d      = src_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;

        if (wr_acc) begin
            pend_val_d = IOBUS_OUT[15:0];
        end

        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                bin_d   = pend_val_q;
                src_d   = pend_val_q;
                bcd_d   = '0;
                iter_d  = '0;
                pend_d  = 1'b0;
                state_d = StShift;
            end
            StShift: begin
                bin_d  = bin_shf;
                bcd_d  = bcd_shf;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    // Commit on the final shift edge so the display changes as DONE is entered.
                    disp_d  = bcd_shf[15:0];
                    ovf_d   = (src_q > 16'd9999);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = pend_q ? StLoad : StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A write landing on the LOAD edge must survive the pend clear.
        if (wr_acc) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        if (cnt_q == CntW'(REFRESH_CNT - 1)) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
            dig_d = dig_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            src_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            dig_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            src_q      <= src_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
        end
    end

    assign BUSY      = (state_q != StIdle);
    assign cur_digit = disp_q[{dig_q, 2'b00} +: 4];

    always_comb begin
        seg = 8'hFF;
        unique case (cur_digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    end

    always_comb begin
        CATHODES = ovf_q ? 8'hBF : seg;
        ANODES   = ~(4'b0001 << dig_q);
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and every higher one is zero; digit 0 always shows.
        if (!ovf_q && (dig_q != 2'd0) && ((disp_q >> {dig_q, 2'b00}) == 16'd0)) begin
            ANODES = 4'b1111;
        end
`endif
    end

endmodule

// File: tb/tb_sseg_mmio_display.sv
// Bench for sseg_mmio_display: directed and random writes checked against a decimal-arithmetic model.
module tb_sseg_mmio_display;

    localparam logic [31:0] Addr = 32'h11000040;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic        BUSY;
    logic [7:0]  CATHODES;
    logic [3:0]  ANODES;

    int checks = 0;
    int errors = 0;
    int k = 0;  // rising edges since the last reset edge

    sseg_mmio_display #(
        .ADDR       (Addr),
        .REFRESH_CNT(4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .BUSY      (BUSY),
        .CATHODES  (CATHODES),
        .ANODES    (ANODES)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) k <= RST_N ? k + 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input int digit);
        case (digit)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [3:0] exp_an(input int v, input int d);
        logic [3:0] one = 4'b0001;
        logic [3:0] an = ~(one << d);
`ifdef LEADING_ZERO_BLANK_EN
        if (v <= 9999 && d > 0 && v < pow10(d)) an = 4'b1111;
`endif
        return an;
    endfunction

    function automatic logic [7:0] exp_cat(input int v, input int d);
        if (v > 9999) return 8'hBF;
        return seg_of((v / pow10(d)) % 10);
    endfunction

    // Check whichever digit slot is currently lit against displayed value v.
    task automatic check_slot(input int v);
        int d = (k / 4) % 4;
        logic [3:0] an = exp_an(v, d);
        check("anodes", {28'd0, ANODES}, {28'd0, an});
        if (an != 4'b1111) check("cathodes", {24'd0, CATHODES}, {24'd0, exp_cat(v, d)});
    endtask

    task automatic check_disp(input int v);
        for (int i = 0; i < 16; i++) begin
            check_slot(v);
            @(negedge CLK);
        end
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    // Called right after an accepted write edge E: BUSY high for edges E+1..E+18, display at E+18.
    task automatic conv(input int old_v, input int new_v);
        check("busy_pre", {31'd0, BUSY}, 32'd0);
        for (int n = 1; n <= 19; n++) begin
            @(negedge CLK);
            check("busy_conv", {31'd0, BUSY}, {31'd0, (n <= 18)});
            if (n == 17) check_slot(old_v);
            if (n == 18) check_slot(new_v);
        end
    endtask

    initial begin
        int v;
        int cur;
        logic [31:0] tmp;
        logic [31:0] wa;

        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_an", {28'd0, ANODES}, 32'hE);
        check("rst_cat", {24'd0, CATHODES}, 32'hC0);
        check_disp(0);

        write(Addr, 32'd1234);
        conv(0, 1234);
        check_disp(1234);

        write(Addr + 32'd4, 32'hFFFF1234);
        for (int i = 0; i < 20; i++) begin
            check("busy_badaddr", {31'd0, BUSY}, 32'd0);
            @(negedge CLK);
        end
        check_disp(1234);
        write(Addr, 32'hABCD0007);
        conv(1234, 7);
        check_disp(7);

        write(Addr, 32'd9999);
        conv(7, 9999);
        check_disp(9999);
        write(Addr, 32'd10000);
        conv(9999, 10000);
        check_disp(10000);
        write(Addr, 32'd65535);
        conv(10000, 65535);
        check_disp(65535);

        // Back-to-back: second write lands mid-conversion and must follow without a BUSY gap.
        write(Addr, 32'd5);
        check("busy_b2b_pre", {31'd0, BUSY}, 32'd0);
        for (int n = 1; n <= 37; n++) begin
            @(negedge CLK);
            if (n == 4) IOBUS_WR = 1'b0;
            check("busy_b2b", {31'd0, BUSY}, {31'd0, (n <= 36)});
            if (n == 17) check_slot(65535);
            if (n == 18 || n == 35) check_slot(5);
            if (n == 36) check_slot(7);
            if (n == 3) begin
                IOBUS_ADDR = Addr;
                IOBUS_OUT  = 32'd7;
                IOBUS_WR   = 1'b1;
            end
        end
        check_disp(7);
        cur = 7;

        for (int r = 0; r < 8; r++) begin
            v   = (r % 2 == 1) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
            tmp = $urandom();
            wa  = Addr ^ (32'd1 << $urandom_range(0, 31));
            write(wa, tmp);
            repeat (3) @(negedge CLK);
            check("busy_rand_bad", {31'd0, BUSY}, 32'd0);
            write(Addr, {tmp[31:16], v[15:0]});
            conv(cur, v);
            check_disp(v);
            cur = v;
        end

        write(Addr, 32'd42);
        conv(cur, 42);
        check_disp(42);

        // Reset during the eighth shift iteration discards the conversion.
        write(Addr, 32'd4321);
        repeat (9) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 30; i++) begin
            check("busy_after_rst", {31'd0, BUSY}, 32'd0);
            check_slot(0);
            @(negedge CLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_mmio_display.md
Name: sseg_mmio_display

Overview:
- Output-side MMIO peripheral for the OTTER MCU; the output counterpart of the SWITCHES input path.
- Captures CPU stores to a fixed I/O address and converts the 16-bit value to 4-digit BCD with a sequential double-dabble engine.
- Time-multiplexes the result onto a 4-digit common-anode seven-segment display.
- Sits inside OTTER_Wrapper alongside the switch/LED I/O decode.

Parameters:
ADDR, 32'h11000040, MMIO address that selects this block.
REFRESH_CNT, 100000, CLK cycles each digit stays lit (>=2); benches use 4.

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST_N  input  1  synchronous, active-low reset
IOBUS_ADDR  input  32  CPU I/O address
IOBUS_OUT  input  32  CPU store data; only [15:0] used, [31:16] ignored
IOBUS_WR  input  1  CPU I/O write strobe
BUSY  output  1  high while a conversion is in progress
CATHODES  output  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}
ANODES  output  4  active-low digit enables; bit0 = ones (rightmost) digit

Behaviour:
- Reset (RST_N==0 at a rising edge):
  - FSM to IDLE; pending flag, pending value, shift regs, refresh counter and digit index cleared.
  - Displayed BCD = 0000; BUSY=0; ANODES=4'b1110; CATHODES=8'hC0.
  - A reset mid-conversion aborts it and discards any pending write.
- Write accept:
  - An edge with IOBUS_WR==1 and IOBUS_ADDR==ADDR latches IOBUS_OUT[15:0] into pend_val and sets pend.
  - Any other address is ignored.
  - A newer write overwrites pend_val (last write wins); writes are never stalled.
- FSM:
  - IDLE: if pend, go to LOAD.
  - LOAD: bin<=pend_val, bcd_work<=0, iter<=0, pend cleared; go to SHIFT. If a write is accepted in the same edge, it re-sets pend (new write wins over clear).
  - SHIFT: one iteration per cycle. Add 3 to each BCD nibble >=5, then shift {bcd_work,bin} left by 1. After the 16th iteration go to DONE.
  - DONE: commit to the display register. If src value >9999, commit the overflow flag (all digits dash); else commit 4 BCD digits. Go to LOAD if pend, else IDLE.
- BUSY:
  - Combinational: BUSY = (state != IDLE).
  - An accepted write at edge E gives LOAD at E+1, SHIFT E+2..E+17, DONE E+18.
  - The display updates at edge E+18; BUSY is low from E+19 unless a further write is pending.
- BCD working register is 20 bits wide so that 65535 is handled without loss. Only the low 16 bits are shown; values >9999 are flagged as overflow.
- Refresh:
  - Counter runs 0..REFRESH_CNT-1. On wrap, digit index advances 0->1->2->3->0.
  - ANODES is active-low one-hot of the digit index.
  - The refresh counter is independent of writes and conversions and is never reset by them.
- Segment codes (active low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF. dp is always 1 (off).
- The display register only changes at DONE, so a partially converted value is never shown.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - A digit whose value and all higher digits are 0 has its anode forced high (off) during its slot.
  - Digit 0 is always shown, so value 0 displays a single "0".
  - The overflow pattern is never blanked.
- Undefined: all four digits are always driven, with leading zeros shown.

Test Plan:
1. RST_N=0 for 2 cycles, then 1 -> BUSY=0, ANODES=1110, CATHODES=C0; anodes cycle 1110->1101->1011->0111 every 4 cycles (REFRESH_CNT=4).
2. Write 1234 to 0x11000040 -> BUSY=1 for exactly 18 cycles. Then per slot: 1110/99, 1101/B0, 1011/A4, 0111/F9.
3. Write 0xFFFF1234 to 0x11000044 -> no state change, BUSY stays 0, display unchanged. Write 0xABCD0007 to ADDR -> 0007 (upper bits ignored).
4. Write 9999 -> all slots 90. Then write 10000 -> all slots BF. Then write 65535 -> all slots BF.
5. Write 5, then write 7 four cycles later (during BUSY). Required:
   - 5 is committed at DONE.
   - LOAD follows immediately and BUSY stays continuously high.
   - Final display is 0007 (F8 in digit 0).
6. Write 4321, assert RST_N=0 at SHIFT iteration 8 -> display 0000, BUSY=0, no later commit of 4321. With LEADING_ZERO_BLANK_EN, write 42 -> slots 2 and 3 show ANODES=1111; slots 0/1 show A4/99.
